// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider.
package cpu_div_pkg;

  localparam int unsigned DIV_DW = 32;
  localparam int unsigned DIV_VW = 16;

  // Quotient reported on divide-by-zero.
  localparam logic [DIV_DW-1:0] DIV_SAT = '1;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StFinish = 2'b10,
    StDone   = 2'b11
  } div_state_e;

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the core and the divider.
interface iter_divider_if
  import cpu_div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) ();

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          round_en;
  logic          busy;
  logic          ack;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  // Core side: issues requests, observes results.
  modport master (
    output start, dividend, divisor, round_en,
    input  busy, ack, quotient, remainder, div_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor, round_en,
    output busy, ack, quotient, remainder, div_zero
  );

endinterface

// File: rtl/iter_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned VW = 16
) (
  input  logic [VW-1:0] prem_i,     // low bits of the current partial remainder
  input  logic          bit_i,      // next dividend bit, MSB first
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   prem_o,
  output logic          q_o
);

  logic [VW:0] shifted;
  logic [VW:0] trial;

  // Trial subtract; keep the difference only when it does not go negative.
  always_comb begin
    shifted = {prem_i, bit_i};
    trial   = shifted - {1'b0, divisor_i};
    q_o     = (shifted >= {1'b0, divisor_i});
    prem_o  = q_o ? trial : shifted;
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional half-LSB
// rounding, saturating divide-by-zero.
module iter_divider
  import cpu_div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  iter_divider_if.slave bus_io
);

  localparam int unsigned CW = $clog2(DW);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          rnd_q, rnd_d;
  logic          dz_q, dz_d;         // latched divisor was zero
  logic [VW:0]   prem_q, prem_d;     // partial remainder
  logic [DW-1:0] qacc_q, qacc_d;     // quotient bits accumulated so far
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dzo_q, dzo_d;       // visible DivZero, updated only in FINISH

  logic [VW:0]   step_prem;
  logic          step_q;
  logic          round_up;

  div_step #(
    .VW (VW)
  ) u_step (
    .prem_i    (prem_q[VW-1:0]),
    .bit_i     (dvd_q[cnt_q]),
    .divisor_i (dvs_q),
    .prem_o    (step_prem),
    .q_o       (step_q)
  );

  // 2*rem >= divisor, evaluated on the final partial remainder.
  assign round_up = ({prem_q, 1'b0} >= {2'b00, dvs_q});

  // Next-state logic: operand latch, per-bit iteration, finish/rounding.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rnd_d   = rnd_q;
    dz_d    = dz_q;
    prem_d  = prem_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          dvd_d   = bus_io.dividend;
          dvs_d   = bus_io.divisor;
          rnd_d   = bus_io.round_en;
          dz_d    = (bus_io.divisor == '0);
          prem_d  = '0;
          qacc_d  = '0;
          cnt_d   = CW'(DW - 1);
          state_d = (bus_io.divisor == '0) ? StFinish : StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        prem_d = step_prem;
        qacc_d = {qacc_q[DW-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFinish: begin
        if (dz_q) begin
          quo_d = {DW{1'b1}};
          rem_d = '0;
        end else begin
          // q is all ones only for divisor 1, where rem is 0, so +1 never wraps.
          quo_d = (rnd_q && round_up) ? qacc_q + DW'(1) : qacc_q;
          rem_d = prem_q[VW-1:0];
        end
        dzo_d   = dz_q;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rnd_q   <= 1'b0;
      dz_q    <= 1'b0;
      prem_q  <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rnd_q   <= rnd_d;
      dz_q    <= dz_d;
      prem_q  <= prem_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
    end
  end

  // Status and result outputs are pure functions of registered state.
  always_comb begin
    bus_io.busy      = (state_q == StRun) || (state_q == StFinish);
    bus_io.ack       = (state_q == StDone);
    bus_io.quotient  = quo_q;
    bus_io.remainder = rem_q;
    bus_io.div_zero  = dzo_q;
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (DW=32, VW=16).
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   extra;

  iter_divider_if #(.DW(32), .VW(16)) bus ();

  iter_divider #(
    .DW (32),
    .VW (16)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_io  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge. Presents Start for one edge, then waits for Ack.
  // lat is the inclusive edge count from the accepting edge to the edge after
  // which Ack is seen (0 if it never comes). Start is re-pulsed with junk
  // operands when the count equals rp0 or rp1.
  task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs, input logic rnd,
                        input int rp0, input int rp1, output int lat_o);
    int n;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.round_en = rnd;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
    bus.round_en = ~rnd;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    n = 1;
    while (!bus.ack && n < 60) begin
      bus.start = (n == rp0) || (n == rp1);
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    lat_o = bus.ack ? n : 0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.round_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ack",  64'(bus.ack), 64'd0);
    chk("rst_quo",  64'(bus.quotient), 64'd0);
    chk("rst_rem",  64'(bus.remainder), 64'd0);
    chk("rst_dz",   64'(bus.div_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2^31 / 4
    run_op(32'h8000_0000, 16'd4, 1'b0, -1, -1, lat);
    chk("t1_lat",  64'(lat), 64'd34);
    chk("t1_quo",  64'(bus.quotient), 64'h2000_0000);
    chk("t1_rem",  64'(bus.remainder), 64'd0);
    chk("t1_dz",   64'(bus.div_zero), 64'd0);
    chk("t1_busy_done", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("t1_ack_one_cycle", 64'(bus.ack), 64'd0);
    chk("t1_hold_quo", 64'(bus.quotient), 64'h2000_0000);

    // 2^31 / 36 = 59652323 r 20, truncated then rounded (40 >= 36)
    run_op(32'h8000_0000, 16'd36, 1'b0, -1, -1, lat);
    chk("t2_lat", 64'(lat), 64'd34);
    chk("t2_quo", 64'(bus.quotient), 64'h038E_38E3);
    chk("t2_rem", 64'(bus.remainder), 64'd20);
    @(posedge clk); #1;
    run_op(32'h8000_0000, 16'd36, 1'b1, -1, -1, lat);
    chk("t3_lat", 64'(lat), 64'd34);
    chk("t3_quo", 64'(bus.quotient), 64'h038E_38E4);
    chk("t3_rem", 64'(bus.remainder), 64'd20);
    @(posedge clk); #1;

    // Divide by zero saturates after two edges
    run_op(32'h1234_5678, 16'd0, 1'b0, -1, -1, lat);
    chk("t4_lat", 64'(lat), 64'd2);
    chk("t4_quo", 64'(bus.quotient), 64'hFFFF_FFFF);
    chk("t4_rem", 64'(bus.remainder), 64'd0);
    chk("t4_dz",  64'(bus.div_zero), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_hold_quo", 64'(bus.quotient), 64'hFFFF_FFFF);
    chk("t4_hold_dz",  64'(bus.div_zero), 64'd1);

    // Divisor 1 with rounding must not wrap; then back-to-back from DONE
    run_op(32'hFFFF_FFFF, 16'd1, 1'b1, -1, -1, lat);
    chk("t5_lat", 64'(lat), 64'd34);
    chk("t5_quo", 64'(bus.quotient), 64'hFFFF_FFFF);
    chk("t5_rem", 64'(bus.remainder), 64'd0);
    chk("t5_dz",  64'(bus.div_zero), 64'd0);
    run_op(32'd100, 16'd7, 1'b0, -1, -1, lat);
    chk("t6_b2b_lat", 64'(lat), 64'd34);
    chk("t6_quo", 64'(bus.quotient), 64'd14);
    chk("t6_rem", 64'(bus.remainder), 64'd2);
    @(posedge clk); #1;

    // Start re-pulsed mid-run is ignored: 65536 / 3 = 21845 r 1
    run_op(32'h0001_0000, 16'd3, 1'b0, 5, 20, lat);
    chk("t7_lat", 64'(lat), 64'd34);
    chk("t7_quo", 64'(bus.quotient), 64'd21845);
    chk("t7_rem", 64'(bus.remainder), 64'd1);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ack) extra++;
    end
    chk("t7_single_ack", 64'(extra), 64'd0);
    chk("t7_hold_quo", 64'(bus.quotient), 64'd21845);

    // Reset at edge 10 of a run abandons it
    bus.start    = 1'b1;
    bus.dividend = 32'h8000_0000;
    bus.divisor  = 16'd36;
    bus.round_en = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t8_busy", 64'(bus.busy), 64'd0);
    chk("t8_ack",  64'(bus.ack), 64'd0);
    chk("t8_quo",  64'(bus.quotient), 64'd0);
    chk("t8_rem",  64'(bus.remainder), 64'd0);
    chk("t8_dz",   64'(bus.div_zero), 64'd0);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ack || bus.busy) extra++;
    end
    chk("t8_no_ack", 64'(extra), 64'd0);
    run_op(32'h8000_0000, 16'd36, 1'b0, -1, -1, lat);
    chk("t9_lat", 64'(lat), 64'd34);
    chk("t9_quo", 64'(bus.quotient), 64'h038E_38E3);
    chk("t9_rem", 64'(bus.remainder), 64'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
